cbus_arbiter: RTL
=================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of cache-side CBus requesters (ICache, DCache, ...), range 2..8.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ireqs  input  NUM_REQ x cbus_req_t  per-requester CBus request.
REQ-005 SHALL have port iresps  output  NUM_REQ x cbus_resp_t  per-requester CBus response.
REQ-006 SHALL have port oreq  output  cbus_req_t  request forwarded to the single memory-side CBus.
REQ-007 SHALL have port oresp  input  cbus_resp_t  memory-side response (ready, last, data).

Function
REQ-008 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one requester owns the bus).
REQ-009 SHALL track registered owner index sel, width clog2(NUM_REQ).
REQ-010 IDLE: if any ireqs[i].valid, SHALL pick a winner per REQ-019/020, latch sel, and enter BUSY on the next edge. Grant latency is exactly 1 cycle.
REQ-011 IDLE: oreq SHALL be all-zero and every iresps[i] SHALL be all-zero.
REQ-012 BUSY: oreq SHALL equal ireqs[sel] combinationally. All fields pass through: valid, is_write, size, addr, strobe, data, len, burst.
REQ-013 BUSY: iresps[sel] SHALL equal oresp. Every other iresps[j] SHALL be all-zero, so ready=0 and last=0.
REQ-014 BUSY -> IDLE SHALL occur on the edge where oresp.ready and oresp.last are both 1. Ownership is held for the whole burst, e.g. 16 beats for MLEN16.
REQ-015 If ireqs[sel].valid drops while BUSY, oreq.valid SHALL follow to 0. Ownership SHALL be retained until the last beat, so a requester cannot lose the bus mid-burst.
REQ-016 Last beat and pending requests in the same cycle: the FSM SHALL return to IDLE first, then arbitrate in the next cycle. This gives one guaranteed bubble cycle between bursts.
REQ-017 Requests from non-owners during BUSY SHALL be ignored, not queued. The requester keeps valid asserted until granted (CBus rule).
REQ-018 sel SHALL change only on the IDLE->BUSY transition.

Configuration
REQ-019 Macro CBUS_ARB_ROUND_ROBIN_EN defined: SHALL keep a registered priority pointer ptr. The winner is the first valid index scanning ptr, ptr+1, ... modulo NUM_REQ. On each grant, ptr <= winner+1 with wrap-around to 0.
REQ-020 Macro CBUS_ARB_ROUND_ROBIN_EN undefined: fixed priority, where the lowest valid index wins. No ptr register SHALL exist.

Reset
REQ-021 While reset==0 at a posedge, SHALL set state=IDLE, sel=0 and ptr=0 (if present).
REQ-022 During and after reset, oreq and all iresps SHALL be all-zero until the first grant.
REQ-023 Reset asserted mid-burst SHALL abandon ownership immediately. No beats SHALL be forwarded after the reset edge.
REQ-024 No reset value SHALL depend on any input.

Verification
REQ-025 Single request: reset released, ireqs[1] read, MLEN4, addr 0x80000040 -> oreq.valid=1 at cycle 2 with addr 0x80000040. iresps[1] mirrors 4 beats. IDLE the cycle after last.
REQ-026 Contention, RR build: ireqs[0] and [1] valid continuously, MLEN16 each -> grants alternate 0,1,0,1. Exactly one idle bubble between bursts. The non-owner always sees ready=0.
REQ-027 Contention, fixed build: same stimulus -> requester 0 wins every arbitration. Requester 1 is granted only once requester 0 is idle for an arbitration cycle.
REQ-028 Mid-burst takeover attempt: owner 1 writing MLEN16, requester 0 asserts at beat 5 -> oreq still carries requester 1 data for beats 5..15. Requester 0 is granted one cycle after beat 15.
REQ-029 Reset mid-burst: reset=0 at beat 7 of 16 -> next cycle oreq.valid=0 and iresps all zero. After release, a fresh request is granted with 1-cycle latency.
REQ-030 Owner drops valid at beat 3 for 2 cycles -> oreq.valid=0 for those cycles. sel is unchanged. Beats resume on reassertion, and release happens only on last.

Source files
------------

// File: rtl/cbus_arbiter.sv
// CBus arbiter: grants one of NUM_REQ cache-side requesters the memory-side CBus for a whole burst.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (lowest index) otherwise.

package cbus_pkg;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned BURST_W = 2;

    typedef struct packed {
        logic               valid;
        logic               is_write;
        logic [SIZE_W-1:0]  size;
        logic [ADDR_W-1:0]  addr;
        logic [STRB_W-1:0]  strobe;
        logic [DATA_W-1:0]  data;
        logic [LEN_W-1:0]   len;
        logic [BURST_W-1:0] burst;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_REQ],
    output cbus_resp_t iresps [NUM_REQ],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] win;
    logic             any_valid;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    int unsigned      idx;

    // First valid requester scanning upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!any_valid && ireqs[idx].valid) begin
                any_valid = 1'b1;
                win       = SEL_W'(idx);
            end
        end
    end
`else
    // Lowest valid index wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && ireqs[k].valid) begin
                any_valid = 1'b1;
                win       = SEL_W'(k);
            end
        end
    end
`endif

    // Next state and bus steering; ownership is only released on the last beat.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        oreq    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                    sel_d   = win;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                    ptr_d   = (win == SEL_W'(NUM_REQ - 1)) ? '0 : win + SEL_W'(1);
`endif
                end
            end
            BUSY: begin
                oreq          = ireqs[sel_q];
                iresps[sel_q] = oresp;
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule
